// File: rtl/cpu_pkg.sv
// Shared definitions for the MIPS core pipeline: word width, bubble encoding,
// fetch FSM states and the pseudo-direct jump target helper.
package cpu_pkg;

  localparam int WORD_W = 32;
  localparam logic [WORD_W-1:0] NOP_INSTR = 32'h0000_0000;
  localparam logic [WORD_W-1:0] PC_STEP = 32'd4;

  typedef enum logic {
    FS_RUN,
    FS_HALT
  } fetch_state_t;

  // Upper nibble of the delay-slot PC concatenated with the word index.
  function automatic logic [WORD_W-1:0] jump_target(input logic [WORD_W-1:0] pc4,
                                                    input logic [25:0] index);
    return (pc4 & 32'hF000_0000) | {4'h0, index, 2'b00};
  endfunction

endpackage

// File: rtl/fetch_stage_pc_next_sel.sv
// Combinational next-PC selection (stall > jump > branch > sequential) and
// the alignment / range fault check on the selected PC.
module pc_next_sel
  import cpu_pkg::*;
#(
  parameter int SIZE_IM = 128
) (
  input  logic [WORD_W-1:0] pc,
  input  logic [WORD_W-1:0] pc4_id,
  input  logic              stall_if,
  input  logic              jump,
  input  logic [25:0]       jump_index,
  input  logic              branch_taken,
  input  logic [WORD_W-1:0] branch_target,
  output logic [WORD_W-1:0] next_pc,
  output logic              next_fault
);

  localparam logic [WORD_W-1:0] PC_LIMIT = WORD_W'(SIZE_IM * 4);

  always_comb begin
    next_pc = pc + PC_STEP;
    if (stall_if) begin
      next_pc = pc;
    end else if (jump) begin
      next_pc = jump_target(pc4_id, jump_index);
    end else if (branch_taken) begin
      next_pc = branch_target;
    end
  end

  // A held PC was already validated when it was loaded, so stalls never fault.
  assign next_fault = !stall_if && ((next_pc[1:0] != 2'b00) || (next_pc >= PC_LIMIT));

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC register, IF/ID pipeline register and RUN/HALT FSM.
// Optional performance counters are enabled with `define FETCH_PERF_CNT_EN.
module fetch_stage
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          SIZE_IM  = 128,
  parameter int          PERF_W   = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall_if,
  input  logic              flush_if,
  input  logic              branch_taken,
  input  logic [WORD_W-1:0] branch_target,
  input  logic              jump,
  input  logic [25:0]       jump_index,
  output logic [WORD_W-1:0] imem_addr,
  input  logic [WORD_W-1:0] imem_instru,
  output logic [WORD_W-1:0] if_id_instru,
  output logic [WORD_W-1:0] if_id_pc4,
  output logic              if_id_valid,
`ifdef FETCH_PERF_CNT_EN
  output logic [PERF_W-1:0] perf_fetch_cnt,
  output logic [PERF_W-1:0] perf_stall_cnt,
`endif
  output logic              fault
);

  fetch_state_t      state, state_next;
  logic [WORD_W-1:0] pc_p0;
  logic [WORD_W-1:0] instru_p1, pc4_p1;
  logic              vld_p1;
  logic              fault_r;
  logic [WORD_W-1:0] next_pc;
  logic              next_fault;
  logic              run, take_fault, load_valid;

  pc_next_sel #(.SIZE_IM(SIZE_IM)) u_sel (
    .pc           (pc_p0),
    .pc4_id       (pc4_p1),
    .stall_if     (stall_if),
    .jump         (jump),
    .jump_index   (jump_index),
    .branch_taken (branch_taken),
    .branch_target(branch_target),
    .next_pc      (next_pc),
    .next_fault   (next_fault)
  );

  assign run        = (state == FS_RUN);
  assign take_fault = run && next_fault;
  assign load_valid = run && !next_fault && !flush_if && !stall_if;

  always_ff @(posedge clk) begin
    if (reset) state <= FS_RUN;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    if (take_fault) state_next = FS_HALT;
  end

  // IF stage: program counter
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_p0   <= RESET_PC;
      fault_r <= 1'b0;
    end else if (take_fault) begin
      fault_r <= 1'b1;
    end else if (run) begin
      pc_p0 <= next_pc;
    end
  end

  // IF/ID boundary
  always_ff @(posedge clk) begin
    if (reset || take_fault || (run && flush_if)) begin
      instru_p1 <= NOP_INSTR;
      pc4_p1    <= '0;
      vld_p1    <= 1'b0;
    end else if (load_valid) begin
      instru_p1 <= imem_instru;
      pc4_p1    <= pc_p0 + PC_STEP;
      vld_p1    <= 1'b1;
    end
  end

`ifdef FETCH_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      perf_fetch_cnt <= '0;
      perf_stall_cnt <= '0;
    end else begin
      if (load_valid)       perf_fetch_cnt <= perf_fetch_cnt + 1'b1;
      if (run && stall_if)  perf_stall_cnt <= perf_stall_cnt + 1'b1;
    end
  end
`endif

  assign imem_addr    = pc_p0;
  assign if_id_instru = instru_p1;
  assign if_id_pc4    = pc4_p1;
  assign if_id_valid  = vld_p1;
  assign fault        = fault_r;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed, table-driven bench for fetch_stage; instruction memory returns
// 32'hAB00_0000 | address so every fetched word identifies its PC.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        reset, stall_if, flush_if, branch_taken, jump;
  logic [31:0] branch_target, imem_addr, imem_instru, if_id_instru, if_id_pc4;
  logic [25:0] jump_index;
  logic        if_id_valid, fault;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_fetch_cnt, perf_stall_cnt;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  assign imem_instru = 32'hAB00_0000 | imem_addr;

  fetch_stage dut (
    .clk          (clk),
    .reset        (reset),
    .stall_if     (stall_if),
    .flush_if     (flush_if),
    .branch_taken (branch_taken),
    .branch_target(branch_target),
    .jump         (jump),
    .jump_index   (jump_index),
    .imem_addr    (imem_addr),
    .imem_instru  (imem_instru),
    .if_id_instru (if_id_instru),
    .if_id_pc4    (if_id_pc4),
    .if_id_valid  (if_id_valid),
`ifdef FETCH_PERF_CNT_EN
    .perf_fetch_cnt(perf_fetch_cnt),
    .perf_stall_cnt(perf_stall_cnt),
`endif
    .fault        (fault)
  );

  typedef struct {
    logic        stall, flush, br;
    logic [31:0] tgt;
    logic        jmp;
    logic [25:0] jidx;
    logic [31:0] e_addr, e_instru, e_pc4;
    logic        e_valid, e_fault;
  } vec_t;

  vec_t tbl[16];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic s, input logic f, input logic b, input logic [31:0] t,
                       input logic j, input logic [25:0] ji);
    stall_if = s; flush_if = f; branch_taken = b; branch_target = t;
    jump = j; jump_index = ji;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all(input string tag, input logic [31:0] a, input logic [31:0] i,
                         input logic [31:0] p, input logic v, input logic f);
    chk({tag, ".addr"},   imem_addr,    a);
    chk({tag, ".instru"}, if_id_instru, i);
    chk({tag, ".pc4"},    if_id_pc4,    p);
    chk({tag, ".valid"},  {31'b0, if_id_valid}, {31'b0, v});
    chk({tag, ".fault"},  {31'b0, fault},       {31'b0, f});
  endtask

  task automatic do_reset();
    reset = 1'b1;
    drive(0, 0, 0, 0, 0, 0);
    reset = 1'b0;
  endtask

  initial begin
    // stall, flush, br, tgt, jmp, jidx, addr, instru, pc4, valid, fault
    tbl[0]  = '{0,0,0,32'h0,  0,26'h0,  32'h04, 32'hAB000000, 32'h04, 1, 0};
    tbl[1]  = '{0,0,0,32'h0,  0,26'h0,  32'h08, 32'hAB000004, 32'h08, 1, 0};
    tbl[2]  = '{1,0,0,32'h0,  0,26'h0,  32'h08, 32'hAB000004, 32'h08, 1, 0};
    tbl[3]  = '{1,0,0,32'h0,  0,26'h0,  32'h08, 32'hAB000004, 32'h08, 1, 0};
    tbl[4]  = '{0,0,0,32'h0,  0,26'h0,  32'h0C, 32'hAB000008, 32'h0C, 1, 0};
    tbl[5]  = '{0,1,1,32'h40, 0,26'h0,  32'h40, 32'h0,        32'h0,  0, 0};
    tbl[6]  = '{0,0,0,32'h0,  0,26'h0,  32'h44, 32'hAB000040, 32'h44, 1, 0};
    tbl[7]  = '{0,0,1,32'h80, 1,26'h10, 32'h40, 32'hAB000044, 32'h48, 1, 0};
    tbl[8]  = '{0,0,0,32'h0,  0,26'h0,  32'h44, 32'hAB000040, 32'h44, 1, 0};
    tbl[9]  = '{0,0,1,32'h10, 0,26'h0,  32'h10, 32'hAB000044, 32'h48, 1, 0};
    tbl[10] = '{1,1,0,32'h0,  0,26'h0,  32'h10, 32'h0,        32'h0,  0, 0};
    tbl[11] = '{0,0,0,32'h0,  0,26'h0,  32'h14, 32'hAB000010, 32'h14, 1, 0};
    tbl[12] = '{0,0,1,32'h22, 0,26'h0,  32'h14, 32'h0,        32'h0,  0, 1};
    tbl[13] = '{1,0,0,32'h0,  0,26'h0,  32'h14, 32'h0,        32'h0,  0, 1};
    tbl[14] = '{0,1,1,32'h40, 1,26'h20, 32'h14, 32'h0,        32'h0,  0, 1};
    tbl[15] = '{0,0,0,32'h0,  0,26'h0,  32'h14, 32'h0,        32'h0,  0, 1};

    reset = 1'b1;
    drive(0, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0);
    reset = 1'b0;
    chk_all("reset", 32'h0, 32'h0, 32'h0, 0, 0);

    for (int k = 0; k < 16; k++) begin
      drive(tbl[k].stall, tbl[k].flush, tbl[k].br, tbl[k].tgt, tbl[k].jmp, tbl[k].jidx);
      chk_all($sformatf("vec%0d", k), tbl[k].e_addr, tbl[k].e_instru, tbl[k].e_pc4,
              tbl[k].e_valid, tbl[k].e_fault);
    end
`ifdef FETCH_PERF_CNT_EN
    chk("perf_fetch", perf_fetch_cnt, 32'd8);
    chk("perf_stall", perf_stall_cnt, 32'd3);
`endif

    // Leaving HALT through reset
    do_reset();
    chk_all("halt_reset", 32'h0, 32'h0, 32'h0, 0, 0);

    // Sequential overflow past the last word
    drive(0, 0, 1, 32'h1F0, 0, 0);
    chk("seq.start", imem_addr, 32'h1F0);
    for (int k = 1; k <= 3; k++) begin
      drive(0, 0, 0, 0, 0, 0);
      chk($sformatf("seq.addr%0d", k), imem_addr, 32'h1F0 + 32'(4 * k));
    end
    chk("seq.last_pc4", if_id_pc4, 32'h1FC);
    drive(0, 0, 0, 0, 0, 0);
    chk_all("seq.ovf", 32'h1FC, 32'h0, 32'h0, 0, 1);
    drive(0, 0, 0, 0, 0, 0);
    chk_all("seq.hold", 32'h1FC, 32'h0, 32'h0, 0, 1);

    // Aligned but out-of-range redirect
    do_reset();
    drive(0, 0, 1, 32'h200, 0, 0);
    chk_all("range", 32'h0, 32'h0, 32'h0, 0, 1);

    // Reset asserted together with a stall mid-run
    do_reset();
    drive(0, 0, 0, 0, 0, 0);
    chk("pre_rst.addr", imem_addr, 32'h4);
    reset = 1'b1;
    drive(1, 0, 0, 0, 0, 0);
    reset = 1'b0;
    chk_all("stall_reset", 32'h0, 32'h0, 32'h0, 0, 0);
`ifdef FETCH_PERF_CNT_EN
    chk("perf_clear", perf_stall_cnt, 32'd0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
